// File: rtl/comp_2_monitor.sv
// Run-length monitor for the 2-bit comparator (comp_2) result lines.
// Counts how many valid samples in a row give the same result. A run becomes
// stable after STABLE_N such samples, and each run reports that once. Any
// illegal g/l/e encoding is reported as an error. Reports sit in a one-deep
// valid/ready holding register. A report that cannot be held is dropped and
// raises the sticky ovf flag.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | no run in progress (after reset or clr)
// ST_TRACK  | run in progress, run_len < STABLE_N
// ST_STABLE | run has reached STABLE_N; stable report already generated
// ST_ERR    | last valid sample had an illegal encoding
module comp_2_monitor #(
   parameter int unsigned STABLE_N = 4,
   parameter int unsigned CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             g,
   input  logic             l,
   input  logic             e,
   input  logic             clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       out_code,
   output logic [CNT_W-1:0] run_len,
   output logic [CNT_W-1:0] cnt_g,
   output logic [CNT_W-1:0] cnt_l,
   output logic [CNT_W-1:0] cnt_e,
   output logic             err,
   output logic             ovf
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_TRACK  = 2'd1,
      ST_STABLE = 2'd2,
      ST_ERR    = 2'd3
   } state_t;

   localparam logic [1:0]       CODE_EQ  = 2'b00;
   localparam logic [1:0]       CODE_LT  = 2'b01;
   localparam logic [1:0]       CODE_GT  = 2'b10;
   localparam logic [1:0]       CODE_ERR = 2'b11;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_N);

   state_t           state_q, state_d;
   logic [1:0]       code_q, code_d;
   logic [CNT_W-1:0] run_len_q, run_len_d;
   logic [CNT_W-1:0] cnt_g_q, cnt_g_d;
   logic [CNT_W-1:0] cnt_l_q, cnt_l_d;
   logic [CNT_W-1:0] cnt_e_q, cnt_e_d;
   logic             err_q, err_d;
   logic             ovf_q, ovf_d;
   logic             out_valid_q, out_valid_d;
   logic [1:0]       out_code_q, out_code_d;

   logic             one_hot;
   logic             legal;
   logic             illegal;
   logic [1:0]       code_in;
   logic [CNT_W-1:0] run_inc;
   logic             rpt_gen;
   logic [1:0]       rpt_code;

   // Classify the incoming sample: legal only when exactly one line is high.
   always_comb begin
      one_hot = 1'b0;
      code_in = CODE_EQ;
      case ({g, l, e})
         3'b001:  begin one_hot = 1'b1; code_in = CODE_EQ; end
         3'b010:  begin one_hot = 1'b1; code_in = CODE_LT; end
         3'b100:  begin one_hot = 1'b1; code_in = CODE_GT; end
         default: begin one_hot = 1'b0; code_in = CODE_EQ; end
      endcase
      legal   = in_valid &  one_hot;
      illegal = in_valid & ~one_hot;
   end

   // Next-state: run tracking, statistics, report generation and handshake.
   always_comb begin
      state_d     = state_q;
      code_d      = code_q;
      run_len_d   = run_len_q;
      cnt_g_d     = cnt_g_q;
      cnt_l_d     = cnt_l_q;
      cnt_e_d     = cnt_e_q;
      err_d       = err_q;
      ovf_d       = ovf_q;
      out_valid_d = out_valid_q;
      out_code_d  = out_code_q;
      rpt_gen     = 1'b0;
      rpt_code    = CODE_EQ;
      // Cannot wrap in ST_TRACK: run_len < STABLE_N < 2^CNT_W there.
      run_inc     = run_len_q + CNT_ONE;

      if (legal) begin
         case (state_q)
            ST_IDLE, ST_ERR: begin
               run_len_d = CNT_ONE;
               code_d    = code_in;
               state_d   = ST_TRACK;
            end
            ST_TRACK: begin
               if (code_in == code_q) begin
                  run_len_d = run_inc;
                  if (run_inc == STABLE_C) begin
                     state_d  = ST_STABLE;
                     rpt_gen  = 1'b1;
                     rpt_code = code_q;
                  end
               end else begin
                  run_len_d = CNT_ONE;
                  code_d    = code_in;
               end
            end
            ST_STABLE: begin
               if (code_in == code_q) begin
                  if (run_len_q != CNT_MAX) begin
                     run_len_d = run_inc;
                  end
               end else begin
                  run_len_d = CNT_ONE;
                  code_d    = code_in;
                  state_d   = ST_TRACK;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase

         case (code_in)
            CODE_GT: if (cnt_g_q != CNT_MAX) cnt_g_d = cnt_g_q + CNT_ONE;
            CODE_LT: if (cnt_l_q != CNT_MAX) cnt_l_d = cnt_l_q + CNT_ONE;
            default: if (cnt_e_q != CNT_MAX) cnt_e_d = cnt_e_q + CNT_ONE;
         endcase
      end else if (illegal) begin
         state_d   = ST_ERR;
         run_len_d = '0;
         err_d     = 1'b1;
         rpt_gen   = 1'b1;
         rpt_code  = CODE_ERR;
      end

      // A report only loads when the slot is empty or is being emptied now.
      if (rpt_gen) begin
         if (!out_valid_q || out_ready) begin
            out_valid_d = 1'b1;
            out_code_d  = rpt_code;
         end else begin
            ovf_d = 1'b1;
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      if (clr) begin
         state_d     = ST_IDLE;
         code_d      = CODE_EQ;
         run_len_d   = '0;
         cnt_g_d     = '0;
         cnt_l_d     = '0;
         cnt_e_d     = '0;
         err_d       = 1'b0;
         ovf_d       = 1'b0;
         out_valid_d = 1'b0;
         out_code_d  = CODE_EQ;
      end
   end

   // State register with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         code_q      <= CODE_EQ;
         run_len_q   <= '0;
         cnt_g_q     <= '0;
         cnt_l_q     <= '0;
         cnt_e_q     <= '0;
         err_q       <= 1'b0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_code_q  <= CODE_EQ;
      end else begin
         state_q     <= state_d;
         code_q      <= code_d;
         run_len_q   <= run_len_d;
         cnt_g_q     <= cnt_g_d;
         cnt_l_q     <= cnt_l_d;
         cnt_e_q     <= cnt_e_d;
         err_q       <= err_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
         out_code_q  <= out_code_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_code  = out_code_q;
   assign run_len   = run_len_q;
   assign cnt_g     = cnt_g_q;
   assign cnt_l     = cnt_l_q;
   assign cnt_e     = cnt_e_q;
   assign err       = err_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_comp_2_monitor.sv
// Bench for comp_2_monitor. Expected report codes are queued when the
// generating sample is driven. A negedge monitor pops the queue on every
// accepted handshake and compares. Run length, counters and flags are
// checked directly after each edge.
module tb_comp_2_monitor;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0, g = 1'b0, l = 1'b0, e = 1'b0, clr = 1'b0;
   logic       out_ready = 1'b1;

   logic       out_valid, out_valid2;
   logic [1:0] out_code, out_code2;
   logic [7:0] run_len, cnt_g, cnt_l, cnt_e;
   logic [2:0] run_len2, cnt_g2, cnt_l2, cnt_e2;
   logic       err, ovf, err2, ovf2;

   int         n_cmp = 0;
   int         n_err = 0;
   logic [1:0] exp_q[$];

   always #5 clk = ~clk;

   comp_2_monitor #(.STABLE_N(4), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .g(g), .l(l), .e(e),
      .clr(clr), .out_valid(out_valid), .out_ready(out_ready),
      .out_code(out_code), .run_len(run_len), .cnt_g(cnt_g), .cnt_l(cnt_l),
      .cnt_e(cnt_e), .err(err), .ovf(ovf)
   );

   comp_2_monitor #(.STABLE_N(4), .CNT_W(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .g(g), .l(l), .e(e),
      .clr(clr), .out_valid(out_valid2), .out_ready(out_ready),
      .out_code(out_code2), .run_len(run_len2), .cnt_g(cnt_g2), .cnt_l(cnt_l2),
      .cnt_e(cnt_e2), .err(err2), .ovf(ovf2)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, then return 1 time unit after the edge.
   task automatic drive(input logic v, input logic gi, input logic li,
                        input logic ei, input logic c, input logic r);
      in_valid  = v;
      g         = gi;
      l         = li;
      e         = ei;
      clr       = c;
      out_ready = r;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic r);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, r);
   endtask

   task automatic do_clr();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      exp_q.delete();
   endtask

   // Scoreboard monitor: inputs are stable from here to the next edge.
   always @(negedge clk) begin
      if (rst_n && !clr && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_report: got code %0d, expected no report (t=%0t)",
                     out_code, $time);
         end else begin
            chk("report_code", int'(out_code), int'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      #2;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_run_len",   run_len, 0);
      chk("rst_err_ovf",   {err, ovf}, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Four equal samples make a stable run with code 00.
      for (int i = 0; i < 4; i++) begin
         if (i == 3) exp_q.push_back(2'b00);
         drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
         chk("t31_run_len", run_len, i + 1);
         chk("t31_out_valid", out_valid, (i == 3) ? 1 : 0);
      end
      chk("t31_cnt_e", cnt_e, 4);
      idle(1'b1);
      chk("t31_out_valid_drop", out_valid, 0);

      // l,l,l,g,g,g,g: only the g run becomes stable.
      do_clr();
      for (int i = 0; i < 7; i++) begin
         if (i == 6) exp_q.push_back(2'b10);
         if (i < 3) drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
         else       drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
         chk("t32_run_len", run_len, (i < 3) ? i + 1 : i - 2);
         chk("t32_out_valid", out_valid, (i == 6) ? 1 : 0);
      end
      chk("t32_cnt_l", cnt_l, 3);
      chk("t32_cnt_g", cnt_g, 4);
      idle(1'b1);

      // Illegal g=l=1, then a legal e.
      exp_q.push_back(2'b11);
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("t33_err", err, 1);
      chk("t33_out_code", out_code, 3);
      chk("t33_run_len", run_len, 0);
      chk("t33_cnts", {cnt_g, cnt_l, cnt_e}, {8'd4, 8'd3, 8'd0});
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      chk("t33_run_len_after", run_len, 1);
      chk("t33_err_sticky", err, 1);
      chk("t33_cnt_e", cnt_e, 1);

      // Back-to-back reports with the held one accepted in the same cycle.
      exp_q.push_back(2'b11);
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      exp_q.push_back(2'b11);
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      chk("t25_out_valid", out_valid, 1);
      chk("t25_ovf", ovf, 0);
      idle(1'b1);
      chk("t25_drain", out_valid, 0);

      // Held report, illegal sample dropped, ovf set.
      do_clr();
      for (int i = 0; i < 4; i++) begin
         if (i == 3) exp_q.push_back(2'b00);
         drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      end
      chk("t34_out_valid", out_valid, 1);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("t34_ovf", ovf, 1);
      chk("t34_code_held", out_code, 0);
      chk("t34_valid_held", out_valid, 1);
      chk("t34_err", err, 1);
      idle(1'b1);
      chk("t34_valid_drop", out_valid, 0);
      chk("t34_ovf_sticky", ovf, 1);

      // Saturation in the CNT_W=3 instance, then clr with a sample.
      do_clr();
      for (int i = 0; i < 9; i++) begin
         if (i == 3) exp_q.push_back(2'b00);
         drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
         if (i == 6) chk("t35_run_len2_7", run_len2, 7);
      end
      chk("t35_run_len2_sat", run_len2, 7);
      chk("t35_cnt_e2_sat", cnt_e2, 7);
      chk("t35_run_len_wide", run_len, 9);
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      exp_q.delete();
      chk("t35_clr_run_len2", run_len2, 0);
      chk("t35_clr_cnt_e2", cnt_e2, 0);
      chk("t35_clr_flags2", {out_valid2, err2, ovf2}, 0);
      chk("t35_clr_run_len", run_len, 0);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("t35_restart2", run_len2, 1);
      chk("t35_restart_cnt_l2", cnt_l2, 1);

      // Asynchronous reset between edges with a report pending.
      do_clr();
      for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("t36_pending", out_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t36_out_valid", out_valid, 0);
      chk("t36_run_len", run_len, 0);
      chk("t36_cnt_e", cnt_e, 0);
      chk("t36_code_flags", {out_code, err, ovf}, 0);
      chk("t36_dut3", {out_valid2, run_len2, cnt_e2}, 0);
      exp_q.delete();
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      chk("t36_restart", run_len, 1);
      chk("t36_no_report", out_valid, 0);

      idle(1'b1);
      idle(1'b1);
      chk("queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
